arbitro_escrita: RTL

Write-port arbiter and scoreboard for the 32×32 register file. Two writeback sources share the file's single write port: requester 0 is the ALU path, requester 1 is the load/multicycle path. Each source gets a one-entry holding buffer. The block grants the port to at most one buffer per cycle and drives RegWrite/WriteRegister/WriteData toward the register file. It also exports a busy mask and a decode stall for registers with a buffered, not-yet-written result.

---
 rtl/arbitro_escrita_pkg.sv | 9 +
 rtl/arbitro_escrita_buffer.sv | 77 +++++++
 rtl/arbitro_escrita.sv | 111 +++++++++++
 3 files changed

// File: rtl/arbitro_escrita_pkg.sv
// Shared register-file constants for the writeback path.
package pacote_regs;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/arbitro_escrita_buffer.sv
// One-entry write holding buffer with full/age tracking.
module buffer_escrita
  import pacote_regs::*;
#(
  parameter int unsigned DATA_W = pacote_regs::DATA_W,
  parameter int unsigned ADDR_W = pacote_regs::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  input  logic              i_other_load,
  input  logic              i_other_keep,
  input  logic              i_other_refill,
  output logic              o_ready,
  output logic              o_full,
  output logic              o_age,
  output logic [ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_load,
  output logic              o_keep,
  output logic              o_refill
);

  logic              r_full;
  logic              r_age;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  logic w_ready;
  logic w_load;
  logic w_keep;
  logic w_refill;
  logic w_age_next;

  // Accept/hold decisions; writes to x0 are accepted but never stored.
  always_comb begin
    w_ready    = ~r_full | i_grant;
    w_load     = i_valid & w_ready & (i_rd != REG_ZERO);
    w_keep     = r_full & ~i_grant;
    w_refill   = w_load & i_grant;
    // Older if we stay put while the other loads, keep our age while both
    // stay put, or take a fresh entry at the edge the other one refills.
    w_age_next = (w_keep & i_other_load)
               | (w_keep & i_other_keep & r_age)
               | (w_load & i_other_refill);
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_age  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_full <= w_load | w_keep;
      r_age  <= w_age_next;
      if (w_load) begin
        r_rd   <= i_rd;
        r_data <= i_data;
      end
    end
  end

  assign o_ready  = w_ready;
  assign o_full   = r_full;
  assign o_age    = r_age;
  assign o_rd     = r_rd;
  assign o_data   = r_data;
  assign o_load   = w_load;
  assign o_keep   = w_keep;
  assign o_refill = w_refill;

endmodule

// File: rtl/arbitro_escrita.sv
// Register-file write-port arbiter with busy scoreboard and decode stall.
module arbitro_escrita
  import pacote_regs::*;
#(
  parameter int unsigned DATA_W = pacote_regs::DATA_W,
  parameter int unsigned ADDR_W = pacote_regs::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_rd,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_rd,
  input  logic [DATA_W-1:0]   req1_data,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                stall
);

  logic              r_rr;
  logic              w_full0, w_full1, w_age0, w_age1;
  logic [ADDR_W-1:0] w_rd0, w_rd1;
  logic [DATA_W-1:0] w_data0, w_data1;
  logic              w_load0, w_load1, w_keep0, w_keep1, w_refill0, w_refill1;
  logic              w_grant0, w_grant1, w_rr_used;
  logic [NUM_REGS-1:0] w_busy;

  buffer_escrita #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf0 (
    .clk(clk), .reset(reset),
    .i_valid(req0_valid), .i_rd(req0_rd), .i_data(req0_data),
    .i_grant(w_grant0),
    .i_other_load(w_load1), .i_other_keep(w_keep1), .i_other_refill(w_refill1),
    .o_ready(req0_ready), .o_full(w_full0), .o_age(w_age0),
    .o_rd(w_rd0), .o_data(w_data0),
    .o_load(w_load0), .o_keep(w_keep0), .o_refill(w_refill0)
  );

  buffer_escrita #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf1 (
    .clk(clk), .reset(reset),
    .i_valid(req1_valid), .i_rd(req1_rd), .i_data(req1_data),
    .i_grant(w_grant1),
    .i_other_load(w_load0), .i_other_keep(w_keep0), .i_other_refill(w_refill0),
    .o_ready(req1_ready), .o_full(w_full1), .o_age(w_age1),
    .o_rd(w_rd1), .o_data(w_data1),
    .o_load(w_load1), .o_keep(w_keep1), .o_refill(w_refill1)
  );

  // Grant from buffer state only: age, then equal-rd ordering, then round-robin.
  always_comb begin
    w_grant0  = 1'b0;
    w_grant1  = 1'b0;
    w_rr_used = 1'b0;
    if (w_full0 && !w_full1) begin
      w_grant0 = 1'b1;
    end else if (!w_full0 && w_full1) begin
      w_grant1 = 1'b1;
    end else if (w_full0 && w_full1) begin
      if (w_age0 != w_age1) begin
        w_grant0 = w_age0;
        w_grant1 = w_age1;
      end else if (w_rd0 == w_rd1) begin
        w_grant0 = 1'b1;
      end else begin
        w_rr_used = 1'b1;
        w_grant0  = ~r_rr;
        w_grant1  = r_rr;
      end
    end
  end

  // Round-robin pointer advances only on tie-broken grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= 1'b0;
    end else if (w_rr_used) begin
      r_rr <= ~r_rr;
    end
  end

  // Register-file write port driven from the granted buffer.
  always_comb begin
    RegWrite      = w_grant0 | w_grant1;
    WriteRegister = '0;
    WriteData     = '0;
    if (w_grant0) begin
      WriteRegister = w_rd0;
      WriteData     = w_data0;
    end else if (w_grant1) begin
      WriteRegister = w_rd1;
      WriteData     = w_data1;
    end
  end

  // Busy decode and decode-stage stall; x0 never reads as busy.
  always_comb begin
    w_busy    = ({{(NUM_REGS-1){1'b0}}, w_full0} << w_rd0)
              | ({{(NUM_REGS-1){1'b0}}, w_full1} << w_rd1);
    w_busy[0] = 1'b0;
    busy_mask = w_busy;
    stall     = ((rs1 != REG_ZERO) & w_busy[rs1])
              | ((rs2 != REG_ZERO) & w_busy[rs2]);
  end

endmodule
